// File: rtl/heap_requester.sv
// heap_requester: sole master of the heap port; single op latency 2, scan latency 2**ADDRESS_BITS+1.
// Requests taken only in IDLE; a pending response holds RESPOND indefinitely with the heap idle.
module heap_requester #(
   parameter int ADDRESS_BITS = 8,
   parameter int DATA_BITS    = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    reqValid,
   output logic                    reqReady,
   input  logic [7:0]              reqAction,
   input  logic [ADDRESS_BITS-1:0] reqArray,
   input  logic                    reqScan,
   output logic                    rspValid,
   input  logic                    rspReady,
   output logic [DATA_BITS-1:0]    rspData,
   output logic                    rspOverflow,
   output logic [7:0]              heapAction,
   output logic [ADDRESS_BITS-1:0] heapArray,
   input  logic [DATA_BITS-1:0]    heapOut
);

   localparam int CW = ADDRESS_BITS + 1;
   localparam int N  = 2 ** ADDRESS_BITS;
   localparam logic [CW-1:0] LAST_ISSUE = CW'(N - 1);
   localparam logic [CW-1:0] SCAN_END   = CW'(N);

   typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, SCAN, RESPOND} state_t;

   state_t                  state, nextState;
   logic [CW-1:0]           count, nextCount;
   logic                    nextReqReady, nextRspValid, nextOverflow;
   logic [DATA_BITS-1:0]    nextRspData;
   logic [7:0]              nextAction;
   logic [ADDRESS_BITS-1:0] nextArray;
   logic [DATA_BITS:0]      sum;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= IDLE;
         count       <= '0;
         reqReady    <= 1'b1;
         rspValid    <= 1'b0;
         rspData     <= '0;
         rspOverflow <= 1'b0;
         heapAction  <= 8'd0;
         heapArray   <= '0;
      end else begin
         state       <= nextState;
         count       <= nextCount;
         reqReady    <= nextReqReady;
         rspValid    <= nextRspValid;
         rspData     <= nextRspData;
         rspOverflow <= nextOverflow;
         heapAction  <= nextAction;
         heapArray   <= nextArray;
      end
   end

   always_comb begin
      nextState    = state;
      nextCount    = count;
      nextReqReady = reqReady;
      nextRspValid = rspValid;
      nextRspData  = rspData;
      nextOverflow = rspOverflow;
      nextAction   = 8'd0;
      nextArray    = heapArray;
      sum          = {1'b0, rspData} + {1'b0, heapOut};

      case (state)
         IDLE: begin
            if (reqValid && reqReady) begin
               nextReqReady = 1'b0;
               nextRspData  = '0;
               nextOverflow = 1'b0;
               nextAction   = reqAction;
               nextCount    = '0;
               if (reqScan) begin
                  nextArray = '0;
                  nextState = SCAN;
               end else begin
                  nextArray = reqArray;
                  nextState = ISSUE;
               end
            end
         end
         ISSUE: nextState = CAPTURE;
         CAPTURE: begin
            nextRspData  = heapOut;
            nextRspValid = 1'b1;
            nextState    = RESPOND;
         end
         SCAN: begin
            // count = edges seen in SCAN; from 1 on, heapOut holds array count-1
            nextCount = count + CW'(1);
            if (count != '0) begin
               nextRspData  = sum[DATA_BITS-1:0];
               nextOverflow = rspOverflow | sum[DATA_BITS];
            end
            if (count < LAST_ISSUE) begin
               nextAction = heapAction;
               nextArray  = heapArray + ADDRESS_BITS'(1);
            end
            if (count == SCAN_END) begin
               nextRspValid = 1'b1;
               nextState    = RESPOND;
            end
         end
         RESPOND: begin
            if (rspReady) begin
               nextRspValid = 1'b0;
               nextReqReady = 1'b1;
               nextState    = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

endmodule
